// File: rtl/v_pipe_query_par.sv
// Associative lookup table with a two-stage query pipeline (compare, response register),
// valid/ready flow control on both sides and saturating hit/miss statistics.
module v_pipe_query_par #(
   parameter int unsigned KEY_W   = 8,
   parameter int unsigned VAL_W   = 32,
   parameter int unsigned ENTRIES = 8,
   parameter int unsigned CNT_W   = 16,
   localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             upd_vld,
   input  logic             upd_op,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic [KEY_W-1:0] upd_key,
   input  logic [VAL_W-1:0] upd_val,
   input  logic             qry_vld,
   input  logic [KEY_W-1:0] qry_key,
   output logic             qry_rdy,
   output logic             rsp_vld,
   output logic             rsp_hit,
   output logic [IDX_W-1:0] rsp_idx,
   output logic [VAL_W-1:0] rsp_val,
   input  logic             rsp_rdy,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   logic [ENTRIES-1:0] tbl_vld_q;
   logic [KEY_W-1:0]   tbl_key_q [ENTRIES];
   logic [VAL_W-1:0]   tbl_val_q [ENTRIES];

   logic             cmp_hit;
   logic [IDX_W-1:0] cmp_idx;
   logic [VAL_W-1:0] cmp_val;

   logic             s1_vld_q, s1_hit_q;
   logic [IDX_W-1:0] s1_idx_q;
   logic [VAL_W-1:0] s1_val_q;
   logic             s2_vld_q, s2_hit_q;
   logic [IDX_W-1:0] s2_idx_q;
   logic [VAL_W-1:0] s2_val_q;

   logic             qry_acc, s2_load, retire;
   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   // Table valid bits are reset; keys and values are plain storage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tbl_vld_q <= '0;
      end else if (upd_vld) begin
         tbl_vld_q[upd_idx] <= upd_op;
      end
   end

   always_ff @(posedge clk) begin
      if (upd_vld && upd_op) begin
         tbl_key_q[upd_idx] <= upd_key;
         tbl_val_q[upd_idx] <= upd_val;
      end
   end

   // Scan from the top so the lowest matching index is the one left standing.
   always_comb begin
      cmp_hit = 1'b0;
      cmp_idx = '0;
      cmp_val = '0;
      for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
         if (tbl_vld_q[i] && (tbl_key_q[i] == qry_key)) begin
            cmp_hit = 1'b1;
            cmp_idx = IDX_W'(i);
            cmp_val = tbl_val_q[i];
         end
      end
   end

   assign retire  = s2_vld_q && rsp_rdy;
   assign s2_load = !s2_vld_q || rsp_rdy;
   assign qry_rdy = !s1_vld_q || s2_load;
   assign qry_acc = qry_vld && qry_rdy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_vld_q <= 1'b0;
         s1_hit_q <= 1'b0;
         s1_idx_q <= '0;
         s1_val_q <= '0;
      end else if (qry_acc) begin
         s1_vld_q <= 1'b1;
         s1_hit_q <= cmp_hit;
         s1_idx_q <= cmp_idx;
         s1_val_q <= cmp_val;
      end else if (s2_load) begin
         s1_vld_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_vld_q <= 1'b0;
         s2_hit_q <= 1'b0;
         s2_idx_q <= '0;
         s2_val_q <= '0;
      end else if (s2_load) begin
         s2_vld_q <= s1_vld_q;
         s2_hit_q <= s1_hit_q;
         s2_idx_q <= s1_idx_q;
         s2_val_q <= s1_val_q;
      end
   end

   // Gate with valid so an emptied stage never shows stale data.
   assign rsp_vld = s2_vld_q;
   assign rsp_hit = s2_vld_q & s2_hit_q;
   assign rsp_idx = s2_vld_q ? s2_idx_q : '0;
   assign rsp_val = s2_vld_q ? s2_val_q : '0;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (clr_cnt) begin
         hit_cnt_d  = '0;
         miss_cnt_d = '0;
      end else if (retire) begin
         if (s2_hit_q && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
         end
         if (!s2_hit_q && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_v_pipe_query_par.sv
// Directed bench for v_pipe_query_par; a second instance with 2-bit counters covers saturation.
module tb_v_pipe_query_par;

   logic        clk = 1'b0;
   logic        rst;
   logic        upd_vld, upd_op;
   logic [2:0]  upd_idx;
   logic [7:0]  upd_key, qry_key;
   logic [31:0] upd_val;
   logic        qry_vld, rsp_rdy, clr_cnt;
   logic        qry_rdy, rsp_vld, rsp_hit;
   logic [2:0]  rsp_idx;
   logic [31:0] rsp_val;
   logic [15:0] hit_cnt, miss_cnt;
   logic        d2_qry_rdy, d2_rsp_vld, d2_rsp_hit;
   logic [2:0]  d2_rsp_idx;
   logic [31:0] d2_rsp_val;
   logic [1:0]  d2_hit_cnt, d2_miss_cnt;

   int checks = 0;
   int errors = 0;
   int exp_hit = 0;
   int exp_miss = 0;
   int accepted;

   always #5 clk = ~clk;

   v_pipe_query_par dut (
      .clk(clk), .rst(rst), .upd_vld(upd_vld), .upd_op(upd_op), .upd_idx(upd_idx),
      .upd_key(upd_key), .upd_val(upd_val), .qry_vld(qry_vld), .qry_key(qry_key),
      .qry_rdy(qry_rdy), .rsp_vld(rsp_vld), .rsp_hit(rsp_hit), .rsp_idx(rsp_idx),
      .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .clr_cnt(clr_cnt), .hit_cnt(hit_cnt),
      .miss_cnt(miss_cnt)
   );

   v_pipe_query_par #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .upd_vld(upd_vld), .upd_op(upd_op), .upd_idx(upd_idx),
      .upd_key(upd_key), .upd_val(upd_val), .qry_vld(qry_vld), .qry_key(qry_key),
      .qry_rdy(d2_qry_rdy), .rsp_vld(d2_rsp_vld), .rsp_hit(d2_rsp_hit),
      .rsp_idx(d2_rsp_idx), .rsp_val(d2_rsp_val), .rsp_rdy(rsp_rdy), .clr_cnt(clr_cnt),
      .hit_cnt(d2_hit_cnt), .miss_cnt(d2_miss_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic install(input logic [2:0] idx, input logic [7:0] key, input logic [31:0] val);
      upd_vld = 1'b1; upd_op = 1'b1; upd_idx = idx; upd_key = key; upd_val = val;
      tick();
      upd_vld = 1'b0;
   endtask

   task automatic chk_cnt(input string tag);
      chk({tag, "_hitcnt"}, 64'(hit_cnt), 64'(exp_hit));
      chk({tag, "_misscnt"}, 64'(miss_cnt), 64'(exp_miss));
   endtask

   // Issue one query with rsp_rdy high; response checked at T+2, counters after retirement.
   task automatic do_query(input string tag, input logic [7:0] key, input logic ehit,
                           input logic [2:0] eidx, input logic [31:0] eval);
      rsp_rdy = 1'b1;
      qry_vld = 1'b1;
      qry_key = key;
      chk({tag, "_qryrdy"}, 64'(qry_rdy), 64'd1);
      tick();
      qry_vld = 1'b0;
      upd_vld = 1'b0;
      chk({tag, "_notyet"}, 64'(rsp_vld), 64'd0);
      tick();
      chk({tag, "_vld"}, 64'(rsp_vld), 64'd1);
      chk({tag, "_hit"}, 64'(rsp_hit), 64'(ehit));
      chk({tag, "_idx"}, 64'(rsp_idx), 64'(eidx));
      chk({tag, "_val"}, 64'(rsp_val), 64'(eval));
      tick();
      if (ehit) exp_hit++; else exp_miss++;
      chk({tag, "_retired"}, 64'(rsp_vld), 64'd0);
      chk_cnt(tag);
   endtask

   initial begin
      rst = 1'b0; upd_vld = 1'b0; upd_op = 1'b0; upd_idx = '0; upd_key = '0; upd_val = '0;
      qry_vld = 1'b0; qry_key = '0; rsp_rdy = 1'b1; clr_cnt = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      chk("rst_qryrdy", 64'(qry_rdy), 64'd1);
      chk("rst_rspvld", 64'(rsp_vld), 64'd0);
      chk("rst_rsphit", 64'(rsp_hit), 64'd0);
      chk("rst_rspidx", 64'(rsp_idx), 64'd0);
      chk("rst_rspval", 64'(rsp_val), 64'd0);
      chk_cnt("rst");

      // Basic install then hit.
      install(3'd3, 8'h5A, 32'hDEADBEEF);
      do_query("basic", 8'h5A, 1'b1, 3'd3, 32'hDEADBEEF);

      // Lowest index priority, then fall through after invalidation.
      install(3'd2, 8'h11, 32'h22222222);
      install(3'd5, 8'h11, 32'h55555555);
      do_query("prio", 8'h11, 1'b1, 3'd2, 32'h22222222);
      upd_vld = 1'b1; upd_op = 1'b0; upd_idx = 3'd2;
      tick();
      upd_vld = 1'b0;
      do_query("inval", 8'h11, 1'b1, 3'd5, 32'h55555555);

      // Same-cycle install is invisible to the accepted query.
      upd_vld = 1'b1; upd_op = 1'b1; upd_idx = 3'd0; upd_key = 8'h22; upd_val = 32'h00001234;
      do_query("samecyc", 8'h22, 1'b0, 3'd0, 32'd0);
      do_query("nextcyc", 8'h22, 1'b1, 3'd0, 32'h00001234);
      do_query("miss", 8'h77, 1'b0, 3'd0, 32'd0);

      // Backpressure: only two queries fit, response held stable.
      rsp_rdy = 1'b0;
      accepted = 0;
      for (int i = 0; i < 5; i++) begin
         qry_vld = 1'b1;
         qry_key = (i == 0) ? 8'h5A : ((i == 1) ? 8'h11 : 8'h22);
         if (i >= 2) begin
            chk("bp_stall_rdy", 64'(qry_rdy), 64'd0);
            chk("bp_stable_idx", 64'(rsp_idx), 64'd3);
            chk("bp_stable_val", 64'(rsp_val), 64'hDEADBEEF);
         end
         if (qry_vld && qry_rdy) accepted++;
         tick();
      end
      chk("bp_accepted", 64'(accepted), 64'd2);
      chk("bp_qryrdy", 64'(qry_rdy), 64'd0);
      chk("bp_vld", 64'(rsp_vld), 64'd1);
      qry_vld = 1'b0;
      rsp_rdy = 1'b1;
      tick();
      chk("bp_second_vld", 64'(rsp_vld), 64'd1);
      chk("bp_second_idx", 64'(rsp_idx), 64'd5);
      chk("bp_second_val", 64'(rsp_val), 64'h55555555);
      tick();
      chk("bp_drained", 64'(rsp_vld), 64'd0);
      exp_hit += 2;
      chk_cnt("bp");

      // Clear counters with the pipeline idle.
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      exp_hit = 0; exp_miss = 0;
      chk_cnt("clr");
      chk("clr_d2", 64'(d2_hit_cnt), 64'd0);

      // Full throughput burst of five hits; 2-bit counter saturates at 3.
      accepted = 0;
      for (int i = 0; i < 5; i++) begin
         qry_vld = 1'b1; qry_key = 8'h5A;
         if (qry_vld && qry_rdy) accepted++;
         if (i >= 2) chk("burst_rspvld", 64'(rsp_vld), 64'd1);
         tick();
      end
      qry_vld = 1'b0;
      tick();
      tick();
      chk("burst_accepted", 64'(accepted), 64'd5);
      chk("burst_drained", 64'(rsp_vld), 64'd0);
      exp_hit += 5;
      chk_cnt("burst");
      chk("sat_d2_hit", 64'(d2_hit_cnt), 64'd3);

      // Clear wins over a same-cycle retiring hit.
      qry_vld = 1'b1; qry_key = 8'h5A;
      tick();
      qry_vld = 1'b0;
      tick();
      chk("clrret_vld", 64'(rsp_vld), 64'd1);
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      exp_hit = 0; exp_miss = 0;
      chk_cnt("clrret");
      chk("clrret_d2", 64'(d2_hit_cnt), 64'd0);

      // Asynchronous reset with both stages full.
      rsp_rdy = 1'b0;
      qry_vld = 1'b1; qry_key = 8'h5A;
      tick();
      tick();
      qry_vld = 1'b0;
      chk("arst_full_vld", 64'(rsp_vld), 64'd1);
      chk("arst_full_rdy", 64'(qry_rdy), 64'd0);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_vld", 64'(rsp_vld), 64'd0);
      chk("arst_hit", 64'(rsp_hit), 64'd0);
      chk("arst_idx", 64'(rsp_idx), 64'd0);
      chk("arst_val", 64'(rsp_val), 64'd0);
      tick();
      rst = 1'b1;
      rsp_rdy = 1'b1;
      chk("arst_qryrdy", 64'(qry_rdy), 64'd1);
      tick();
      chk("arst_noresp", 64'(rsp_vld), 64'd0);
      chk_cnt("arst");
      do_query("arst_miss", 8'h5A, 1'b0, 3'd0, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/v_pipe_query_par.md
V_PIPE_QUERY_PAR -- requirements
Module: v_pipe_query_par

Interface
REQ-001 Parameter KEY_W, default 8: query/tag key width in bits.
REQ-002 Parameter VAL_W, default 32: stored value width in bits.
REQ-003 Parameter ENTRIES, default 8: table depth. Power of two, >= 2. IDX_W = log2(ENTRIES).
REQ-004 Parameter CNT_W, default 16: width of the hit and miss statistics counters.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous assert, active-low (0 = reset); one clock; reset is asynchronous and active-low.
REQ-007 upd_vld  in  1  table update strobe; always accepted.
REQ-008 upd_op  in  1  1 = install entry (set valid), 0 = invalidate entry.
REQ-009 upd_idx  in  IDX_W  entry index to update.
REQ-010 upd_key  in  KEY_W  key to install.
REQ-011 upd_val  in  VAL_W  value to install.
REQ-012 qry_vld  in  1  query request valid.
REQ-013 qry_key  in  KEY_W  query key.
REQ-014 qry_rdy  out  1  query request accepted when qry_vld && qry_rdy.
REQ-015 rsp_vld  out  1  response valid.
REQ-016 rsp_hit  out  1  1 = key matched a valid entry.
REQ-017 rsp_idx  out  IDX_W  matching index; 0 on miss.
REQ-018 rsp_val  out  VAL_W  matching value; 0 on miss.
REQ-019 rsp_rdy  in  1  consumer ready; response retired when rsp_vld && rsp_rdy.
REQ-020 clr_cnt  in  1  synchronous clear of both statistics counters.
REQ-021 hit_cnt  out  CNT_W  retired-hit count, saturating.
REQ-022 miss_cnt  out  CNT_W  retired-miss count, saturating.

Function
REQ-023 Table: ENTRIES registers of {valid, key, value}; upd_vld writes entry upd_idx at the clock edge; install sets valid/key/value; invalidate clears valid only.
REQ-024 Pipeline: two stages, S1 (compare) and S2 (response register); each holds a valid bit.
REQ-025 Acceptance: the compare uses table state before any same-cycle update (an update at the acceptance cycle is not visible to that query).
REQ-026 Match priority: lowest matching valid index wins; S1 captures hit, idx, val at acceptance; later table updates do not alter an in-flight result.
REQ-027 Latency: a query accepted at cycle T has rsp_vld = 1 at T+2 when rsp_rdy has been 1 throughout.
REQ-028 S2 advance: S2 loads from S1 when S2 is empty or retiring (rsp_vld && rsp_rdy).
REQ-029 qry_rdy = !S1.valid || S1 advancing into S2. qry_rdy is combinational from rsp_rdy and state, not from qry_vld.
REQ-030 Full throughput: with rsp_rdy = 1 continuously, one query accepted and one response retired per cycle.
REQ-031 Backpressure: while rsp_vld && !rsp_rdy, rsp_* hold stable. When S1 is also full, qry_rdy = 0. No response is lost, duplicated or reordered.
REQ-032 Counters: on retirement, hit_cnt += rsp_hit, miss_cnt += !rsp_hit. Each counter saturates at 2^CNT_W-1.
REQ-033 clr_cnt: both counters read 0 next cycle. It overrides a same-cycle increment.
REQ-034 Miss output: on a miss, rsp_idx and rsp_val are 0.

Reset
REQ-035 rst = 0 asynchronously clears: all entry valid bits, S1/S2 valid, hit_cnt, miss_cnt. Keys and values need not be reset.
REQ-036 Outputs during and after reset: rsp_vld = 0, rsp_hit = 0, rsp_idx = 0, rsp_val = 0.
REQ-037 After reset, qry_rdy = 1 in the first cycle with rst = 1.
REQ-038 Reset mid-operation discards in-flight queries without producing a response.

Verification
REQ-039 Install idx3 key 0x5A val 0xDEADBEEF; next cycle query 0x5A with rsp_rdy = 1 -> two cycles later rsp_vld = 1, hit = 1, idx = 3, val = 0xDEADBEEF, hit_cnt = 1.
REQ-040 Install key 0x11 at idx 2 and idx 5; query 0x11 -> hit = 1, idx = 2. Invalidate idx 2; query 0x11 -> idx = 5.
REQ-041 Same cycle: install idx0 key 0x22 and query 0x22 -> miss = 1, miss_cnt = 1. Next-cycle query 0x22 -> hit.
REQ-042 rsp_rdy = 0 for 5 cycles with qry_vld = 1 continuously -> exactly 2 queries accepted, qry_rdy = 0 thereafter, rsp_* stable. After release, responses arrive in order, one per cycle.
REQ-043 CNT_W = 2, 5 consecutive hits -> hit_cnt = 3 (saturated). clr_cnt with a retiring hit -> hit_cnt = 0.
REQ-044 Assert rst with S1 and S2 full -> rsp_vld = 0 immediately. After release, query of a previously installed key -> miss.
